trb_pkt_dispatch: RTL



---
 rtl/trb_pkt_dispatch_if.sv | 23 ++
 rtl/trb_pkt_dispatch.sv | 124 ++++++++++++
 2 files changed

// File: rtl/trb_pkt_dispatch_if.sv
// Host-beat and lane-side signal bundle for the turbo packet dispatcher.
// The master modport is the host/lane side; the slave modport is the dispatcher.
interface trb_pkt_dispatch_if #(
    parameter int BUS       = 534,
    parameter int NUM_TURBO = 4
);
    logic [BUS-1:0]       bus_data;
    logic                 bus_en;
    logic                 bus_ready;
    logic [NUM_TURBO-1:0] lane_ready;
    logic [NUM_TURBO-1:0] lane_en;
    logic [BUS-1:0]       lane_data;

    modport master (
        output bus_data, bus_en, lane_ready,
        input  bus_ready, lane_en, lane_data
    );

    modport slave (
        input  bus_data, bus_en, lane_ready,
        output bus_ready, lane_en, lane_data
    );
endinterface

// File: rtl/trb_pkt_dispatch.sv
// Steers whole turbo packets from the host bus to one of NUM_TURBO lanes,
// round-robin over ready lanes, with one arbitration bubble per packet.
module trb_pkt_dispatch #(
    parameter int BUS           = 534,
    parameter int NUM_TURBO     = 4,
    parameter int BEATS_PER_PKT = 25
) (
    input  logic                  clk_bus,
    input  logic                  rst_n,
    trb_pkt_dispatch_if.slave     bif,
    output logic [3:0]            cur_lane,
    output logic [15:0]           pkt_cnt,
    output logic                  err_drop
);
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_PKT - 1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     beat_cnt_r;
    logic [3:0]           cur_lane_r;
    logic [15:0]          pkt_cnt_r;
    logic                 err_drop_r;
    logic                 bus_ready_r;
    logic [NUM_TURBO-1:0] lane_en_r;
    logic [BUS-1:0]       lane_data_r;

    logic                 found_hi_s;
    logic                 found_lo_s;
    logic [3:0]           win_hi_s;
    logic [3:0]           win_lo_s;
    logic                 found_s;
    logic [3:0]           winner_s;
    logic [NUM_TURBO-1:0] lane_sel_s;
    logic                 cur_ready_s;
    logic                 accept_s;

    // Round-robin search: lowest ready lane above cur_lane, else lowest at or below it.
    always_comb begin
        found_hi_s  = 1'b0;
        found_lo_s  = 1'b0;
        win_hi_s    = 4'd0;
        win_lo_s    = 4'd0;
        lane_sel_s  = '0;
        cur_ready_s = 1'b0;
        for (int j = NUM_TURBO - 1; j >= 0; j--) begin
            if (bif.lane_ready[j] && (4'(j) > cur_lane_r)) begin
                found_hi_s = 1'b1;
                win_hi_s   = 4'(j);
            end else if (bif.lane_ready[j]) begin
                found_lo_s = 1'b1;
                win_lo_s   = 4'(j);
            end else begin
                found_lo_s = found_lo_s;
            end
            lane_sel_s[j] = (cur_lane_r == 4'(j));
            cur_ready_s   = cur_ready_s | (bif.lane_ready[j] & lane_sel_s[j]);
        end
        found_s  = found_hi_s | found_lo_s;
        winner_s = found_hi_s ? win_hi_s : win_lo_s;
        accept_s = bif.bus_en & bus_ready_r;
    end

    // Arbitration/transfer FSM with registered handshake, strobes and statistics.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            state_r     <= ST_ARB;
            beat_cnt_r  <= '0;
            cur_lane_r  <= 4'(NUM_TURBO - 1);
            pkt_cnt_r   <= 16'd0;
            err_drop_r  <= 1'b0;
            bus_ready_r <= 1'b0;
            lane_en_r   <= '0;
            lane_data_r <= '0;
        end else begin
            lane_en_r <= '0;
            if (bif.bus_en && !bus_ready_r) begin
                err_drop_r <= 1'b1;
            end
            case (state_r)
                ST_ARB: begin
                    if (found_s) begin
                        cur_lane_r  <= winner_s;
                        beat_cnt_r  <= '0;
                        bus_ready_r <= 1'b1;
                        state_r     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept_s) begin
                        lane_en_r   <= lane_sel_s;
                        lane_data_r <= bif.bus_data;
                        if (beat_cnt_r == LAST_BEAT) begin
                            beat_cnt_r  <= '0;
                            bus_ready_r <= 1'b0;
                            pkt_cnt_r   <= pkt_cnt_r + 16'd1;
                            state_r     <= ST_ARB;
                        end else begin
                            beat_cnt_r  <= beat_cnt_r + CNT_W'(1);
                            bus_ready_r <= cur_ready_s;
                        end
                    end else begin
                        bus_ready_r <= cur_ready_s;
                    end
                end
                default: begin
                    state_r     <= ST_ARB;
                    bus_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bif.bus_ready = bus_ready_r;
    assign bif.lane_en   = lane_en_r;
    assign bif.lane_data = lane_data_r;
    assign cur_lane      = cur_lane_r;
    assign pkt_cnt       = pkt_cnt_r;
    assign err_drop      = err_drop_r;
endmodule
